// File: rtl/ps2_keyboard_cmd_pkg.sv
// Shared scan codes, command encodings and state types for the PS/2 keyboard
// command path.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;

    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_LEFT   = 2'b01,
        CMD_RIGHT  = 2'b10,
        CMD_ROTATE = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

    typedef enum logic [1:0] {D_NORM, D_EXT, D_BRK, D_EXT_BRK} decState_t;

    // Plain and E0-prefixed codes share no game keys, so the prefix selects the table.
    function automatic cmd_t mapCode(input logic [7:0] code, input logic ext);
        cmd_t c;
        c = CMD_IDLE;
        if (ext) begin
            case (code)
                SC_LEFT:  c = CMD_LEFT;
                SC_RIGHT: c = CMD_RIGHT;
                SC_UP:    c = CMD_ROTATE;
                default:  c = CMD_IDLE;
            endcase
        end else begin
            case (code)
                SC_A:    c = CMD_LEFT;
                SC_D:    c = CMD_RIGHT;
                SC_W:    c = CMD_ROTATE;
                default: c = CMD_IDLE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/ps2_keyboard_cmd_if.sv
// Keyboard-side bundle: raw PS/2 pins in, game command and frame status out.
interface ps2_keyboard_cmd_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [1:0] keyboard_signal;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output keyboard_signal, rx_valid, rx_byte, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  keyboard_signal, rx_valid, rx_byte, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_cmd_rx_frame.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, 11-bit frame
// FSM with odd-parity check and an inter-edge timeout.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    clkSync, dataSync;
    logic          filtClk, strobe;
    logic [FW-1:0] filtCnt;

    rxState_t      state, stateNext;
    logic [2:0]    bitCnt, bitCntNext;
    logic [7:0]    shiftReg, shiftNext;
    logic          parityBit, parityNext;
    logic [TW-1:0] toCnt;
    logic          validNext, errNext, timeoutHit, dataBit;

    assign dataBit = dataSync[1];

    // The filtered clock only follows after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync  <= '1;
            dataSync <= '1;
            filtClk  <= 1'b1;
            filtCnt  <= '0;
            strobe   <= 1'b0;
        end else begin
            clkSync  <= {clkSync[0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
            strobe   <= 1'b0;
            if (clkSync[1] == filtClk) begin
                filtCnt <= '0;
            end else if (filtCnt == FW'(FILTER_LEN - 1)) begin
                filtClk <= clkSync[1];
                filtCnt <= '0;
                strobe  <= filtClk;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end
    end

    assign timeoutHit = (state != RX_IDLE) && !strobe && (toCnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        parityNext = parityBit;
        validNext  = 1'b0;
        errNext    = 1'b0;
        if (timeoutHit) begin
            errNext   = 1'b1;
            stateNext = RX_IDLE;
        end else if (strobe) begin
            case (state)
                RX_IDLE: begin
                    if (!dataBit) begin
                        stateNext  = RX_DATA;
                        bitCntNext = '0;
                    end else begin
                        errNext = 1'b1;
                    end
                end
                RX_DATA: begin
                    shiftNext  = {dataBit, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) stateNext = RX_PARITY;
                end
                RX_PARITY: begin
                    parityNext = dataBit;
                    stateNext  = RX_STOP;
                end
                RX_STOP: begin
                    if (dataBit && (^{shiftReg, parityBit})) validNext = 1'b1;
                    else                                     errNext   = 1'b1;
                    stateNext = RX_IDLE;
                end
                default: stateNext = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            toCnt     <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftNext;
            parityBit <= parityNext;
            rx_valid  <= validNext;
            frame_err <= errNext;
            if (validNext) rx_byte <= shiftReg;
            if (state == RX_IDLE || strobe || timeoutHit) toCnt <= '0;
            else                                          toCnt <= toCnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_keyboard_cmd.sv
// Keyboard command front end: turns PS/2 make/break sequences into single-cycle
// game command pulses, suppressing typematic repeats unless REPEAT_EN is set.
module ps2_keyboard_cmd
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter bit          REPEAT_EN      = 1'b0
) (
    input logic               clk,
    input logic               rst,
    ps2_keyboard_cmd_if.master kbd
);

    logic       rxValid, frameErr;
    logic [7:0] rxByte;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (kbd.ps2_clk),
        .ps2_data (kbd.ps2_data),
        .rx_valid (rxValid),
        .rx_byte  (rxByte),
        .frame_err(frameErr)
    );

    decState_t decState, decNext;
    cmd_t      held, heldNext, pulse, pulseNext, code;
    logic      isBreak;

    assign isBreak = (decState == D_BRK) || (decState == D_EXT_BRK);
    assign code    = mapCode(rxByte, (decState == D_EXT) || (decState == D_EXT_BRK));

    always_comb begin
        decNext   = decState;
        heldNext  = held;
        pulseNext = CMD_IDLE;
        if (frameErr) begin
            decNext = D_NORM;
        end else if (rxValid) begin
            if (rxByte == SC_EXT && decState == D_NORM) begin
                decNext = D_EXT;
            end else if (rxByte == SC_BREAK && decState == D_NORM) begin
                decNext = D_BRK;
            end else if (rxByte == SC_BREAK && decState == D_EXT) begin
                decNext = D_EXT_BRK;
            end else begin
                decNext = D_NORM;
                if (!isBreak) begin
                    if (code != CMD_IDLE) begin
                        if (held != code || REPEAT_EN) pulseNext = code;
                        heldNext = code;
                    end
                end else if (code != CMD_IDLE && code == held) begin
                    heldNext = CMD_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decState <= D_NORM;
            held     <= CMD_IDLE;
            pulse    <= CMD_IDLE;
        end else begin
            decState <= decNext;
            held     <= heldNext;
            pulse    <= pulseNext;
        end
    end

    assign kbd.keyboard_signal = pulse;
    assign kbd.rx_valid        = rxValid;
    assign kbd.rx_byte         = rxByte;
    assign kbd.frame_err       = frameErr;

endmodule

// File: tb/tb_ps2_keyboard_cmd.sv
// Directed bench for ps2_keyboard_cmd: two instances (repeat off/on) share the
// PS/2 lines; expected command pulses are queued and popped as they appear.
module tb_ps2_keyboard_cmd;
    import ps2_kbd_pkg::*;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 3000;
    localparam int unsigned HALF = 30;
    localparam int unsigned GAP  = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;

    always #5 clk = ~clk;

    ps2_keyboard_cmd_if if0 ();
    ps2_keyboard_cmd_if if1 ();

    assign if0.ps2_clk  = ps2c;
    assign if0.ps2_data = ps2d;
    assign if1.ps2_clk  = ps2c;
    assign if1.ps2_data = ps2d;

    ps2_keyboard_cmd #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .REPEAT_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .kbd(if0.master));
    ps2_keyboard_cmd #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .REPEAT_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .kbd(if1.master));

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int lastRv0 = -10;
    int lastRv1 = -10;
    int rvCnt  = 0;
    int errCnt = 0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every non-idle command must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (if0.rx_valid) begin
                rvCnt++;
                lastRv0 = cyc;
            end
            if (if0.frame_err) errCnt++;
            if (if1.rx_valid) lastRv1 = cyc;
            if (if0.keyboard_signal != 2'b00) begin
                chk("dut0_latency", cyc - lastRv0, 1);
                if (q0.size() == 0) chk("dut0_unexpected_pulse", int'(if0.keyboard_signal), 0);
                else chk("dut0_pulse", int'(if0.keyboard_signal), int'(q0.pop_front()));
            end
            if (if1.keyboard_signal != 2'b00) begin
                chk("dut1_latency", cyc - lastRv1, 1);
                if (q1.size() == 0) chk("dut1_unexpected_pulse", int'(if1.keyboard_signal), 0);
                else chk("dut1_pulse", int'(if1.keyboard_signal), int'(q1.pop_front()));
            end
        end
    end

    task automatic sendBits(input logic [7:0] b, input bit badPar, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            ps2d = f[i];
            repeat (HALF) @(posedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b);
        sendBits(b, 1'b0, 11);
        repeat (GAP) @(posedge clk);
    endtask

    task automatic checkQueues(input string tag);
        chk({tag, "_q0_drained"}, q0.size(), 0);
        chk({tag, "_q1_drained"}, q1.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_kbd0"}, int'(if0.keyboard_signal), 0);
        chk({tag, "_kbd1"}, int'(if1.keyboard_signal), 0);
        chk({tag, "_rx_valid"}, int'(if0.rx_valid), 0);
        chk({tag, "_rx_byte"}, int'(if0.rx_byte), 0);
        chk({tag, "_frame_err"}, int'(if0.frame_err), 0);
    endtask

    initial begin
        int rvB, errB;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // A press: single left pulse, then release
        q0.push_back(CMD_LEFT);
        q1.push_back(CMD_LEFT);
        sendFrame(SC_A);
        chk("rx_byte_1C", int'(if0.rx_byte), 8'h1C);
        chk("rx_valid_count_1", rvCnt, 1);
        checkQueues("a_make");
        sendFrame(SC_BREAK);
        sendFrame(SC_A);
        checkQueues("a_break");

        // Extended up make/break
        q0.push_back(CMD_ROTATE);
        q1.push_back(CMD_ROTATE);
        sendFrame(SC_EXT);
        sendFrame(SC_UP);
        checkQueues("up_make");
        sendFrame(SC_EXT);
        sendFrame(SC_BREAK);
        sendFrame(SC_UP);
        chk("rx_byte_75", int'(if0.rx_byte), 8'h75);
        checkQueues("up_break");

        // Typematic D
        q0.push_back(CMD_RIGHT);
        repeat (3) q1.push_back(CMD_RIGHT);
        repeat (3) sendFrame(SC_D);
        checkQueues("typematic");
        sendFrame(SC_BREAK);
        sendFrame(SC_D);

        // Corrupted parity on W, then clean W
        rvB  = rvCnt;
        errB = errCnt;
        sendBits(SC_W, 1'b1, 11);
        repeat (GAP) @(posedge clk);
        chk("parity_no_valid", rvCnt, rvB);
        chk("parity_frame_err", errCnt, errB + 1);
        chk("parity_rx_byte_held", int'(if0.rx_byte), 8'h23);
        q0.push_back(CMD_ROTATE);
        q1.push_back(CMD_ROTATE);
        sendFrame(SC_W);
        checkQueues("w_after_err");
        sendFrame(SC_BREAK);
        sendFrame(SC_W);

        // Timeout after E0: the prefix must be dropped, so plain 6B is ignored
        sendFrame(SC_EXT);
        errB = errCnt;
        sendBits(SC_LEFT, 1'b0, 4);
        repeat (TMO / 2) @(posedge clk);
        chk("no_early_timeout", errCnt, errB);
        repeat (TMO) @(posedge clk);
        chk("timeout_frame_err", errCnt, errB + 1);
        sendFrame(SC_LEFT);
        checkQueues("plain_6B");
        q0.push_back(CMD_LEFT);
        q1.push_back(CMD_LEFT);
        sendFrame(SC_EXT);
        sendFrame(SC_LEFT);
        checkQueues("ext_left");

        // Reset in the middle of a frame
        rvB = rvCnt;
        sendBits(SC_D, 1'b0, 5);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("midframe_reset");
        rst = 1'b0;
        repeat (GAP) @(posedge clk);
        chk("reset_no_valid", rvCnt, rvB);
        q0.push_back(CMD_RIGHT);
        q1.push_back(CMD_RIGHT);
        sendFrame(SC_EXT);
        sendFrame(SC_RIGHT);
        checkQueues("ext_right");

        // New make while right held replaces it; break of non-held right is ignored
        q0.push_back(CMD_LEFT);
        q1.push_back(CMD_LEFT);
        sendFrame(SC_A);
        checkQueues("replace_held");
        sendFrame(SC_EXT);
        sendFrame(SC_BREAK);
        sendFrame(SC_RIGHT);
        q1.push_back(CMD_LEFT);
        sendFrame(SC_A);
        checkQueues("nonheld_break");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_cmd.md
Name: ps2_keyboard_cmd

Overview:
Receives PS/2 keyboard frames and converts key presses into the 2-bit game command consumed by the Tetris game controller (00 idle, 01 left, 10 right, 11 rotate). It is the producing end of the keyboard_signal interface and sits between the board PS/2 pins and the game control logic. It emits exactly one single-cycle command pulse per fresh key press and suppresses typematic repeats and break codes.

Parameters:
FILTER_LEN, 8, consecutive clk samples for which a synchronised ps2_clk level must be stable before an edge is accepted.
TIMEOUT_CYCLES, 200000, clk cycles with no accepted ps2_clk falling edge inside a frame before the frame is aborted (2 ms at 100 MHz).
REPEAT_EN, 0, when 1, typematic repeats of the held key emit pulses again.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
keyboard_signal  out  2  command pulse: 00 idle, 01 left, 10 right, 11 rotate; non-zero for exactly one cycle
rx_valid  out  1  one-cycle strobe when a frame passes all checks
rx_byte  out  8  last good scan byte; held until the next good frame
frame_err  out  1  one-cycle strobe on a parity, start, stop or timeout error

Behaviour:
- Reset (synchronous, active-high; wins over any same-cycle event): keyboard_signal=00, rx_valid=0, rx_byte=00, frame_err=0. Synchronisers load 1. Receiver goes to IDLE, decoder to D_NORM, held=00, timeout counter=0.
- Input conditioning: 2-flop synchroniser on each of ps2_clk and ps2_data. A glitch filter then updates the filtered clock only after FILTER_LEN equal samples. A falling edge of the filtered clock produces a one-cycle sample strobe, and the synchronised ps2_data is sampled on that strobe.
- Receiver FSM: IDLE -> DATA -> PARITY -> STOP.
  - IDLE: on strobe, data=0 goes to DATA with the bit count cleared. data=1 is a start error: pulse frame_err and stay in IDLE.
  - DATA: shift 8 bits LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit. Odd parity over the 9 bits is required.
  - STOP: on strobe, data=1 with good parity pulses rx_valid and loads rx_byte the next cycle. Otherwise pulse frame_err. Either way return to IDLE.
  - Timeout: in any non-IDLE state, the counter reaching TIMEOUT_CYCLES-1 with no strobe pulses frame_err and returns to IDLE. The counter clears on every strobe and in IDLE.
- Decoder FSM: states D_NORM, D_EXT (after E0), D_BRK (after F0), D_EXT_BRK (after E0 F0). It advances only on rx_valid.
  - E0 moves D_NORM->D_EXT. F0 moves D_NORM->D_BRK and D_EXT->D_EXT_BRK.
  - Any other byte is a code: make if the state is D_NORM/D_EXT, break if D_BRK/D_EXT_BRK. The decoder then returns to D_NORM.
  - Map: plain 1C(A)=01, 23(D)=10, 1D(W)=11. Extended 6B(left)=01, 74(right)=10, 75(up)=11. All other codes map to 00 and are ignored.
  - frame_err forces the decoder back to D_NORM without changing held.
- Command output: keyboard_signal is registered. Latency is 1 cycle after the rx_valid of the final code byte.
  - Make of cmd c!=00: pulse c if held!=c or REPEAT_EN=1, then held<=c.
  - Break of c with c==held: held<=00. A break of a non-held key is ignored.
  - A new make while another key is held pulses immediately and replaces held.
- Pulses cannot collide: consecutive bytes are at least 1 frame apart (about 1 ms).

Decomposition:
- Package ps2_kbd_pkg: scan-code constants (E0, F0, 1C, 23, 1D, 6B, 74, 75), command encodings CMD_IDLE/LEFT/RIGHT/ROTATE, and the receiver/decoder state encodings.
- Sub-module ps2_rx_frame: synchroniser, filter, receiver FSM and timeout, with outputs rx_valid, rx_byte and frame_err.
- The top level holds the decoder FSM, held register and command pulse.

Test Plan:
- Frame 1C with good parity -> rx_byte=1C, one cycle of keyboard_signal=01, then 00 again.
- Frames E0,75 then E0,F0,75 -> one pulse 11 only; no pulse on break; held returns to 00.
- Frames 23,23,23 (typematic) with REPEAT_EN=0 -> a single 10 pulse. With REPEAT_EN=1 -> three 10 pulses.
- Frame 1D with a corrupted parity bit -> frame_err pulse, rx_valid=0, keyboard_signal stays 00. A following clean 1D -> 11 pulse.
- Send 4 bits of a frame, then idle for TIMEOUT_CYCLES -> frame_err at the timeout. A subsequent clean 6B after E0 -> 01 pulse.
- Assert rst midway through frame 23, then release -> all outputs 0, no pulse. The next full E0,74 -> 10 pulse.
